// File: rtl/tour_cmd.sv
// Tour command issuer: UART passthrough in idle, knight-move legs during a tour.
// Optional mid-tour abort via UART opcode F when TOUR_CMD_ABORT_EN is defined.
module tour_cmd #(
  parameter int NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp
);

  typedef enum logic [2:0] {
    IDLE, VERT, VERT_WAIT, HORZ, HORZ_WAIT
  } state_t;

  state_t state, nxt;

  logic        last;
  logic        abort_q;
  logic        abort_set;
  logic        v_north;
  logic        h_east;
  logic [2:0]  v_sq;
  logic [2:0]  h_sq;
  logic [15:0] cmd_v;
  logic [15:0] cmd_h;

  assign last = (mv_indx == 5'(NUM_MOVES - 1));

`ifdef TOUR_CMD_ABORT_EN
  assign abort_set = (state != IDLE) && cmd_rdy_UART &&
                     (cmd_UART[15:12] == 4'hF) && !abort_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      abort_q <= 1'b0;
    else if (nxt == IDLE)
      abort_q <= 1'b0;
    else if (abort_set)
      abort_q <= 1'b1;
  end
`else
  assign abort_set = 1'b0;
  assign abort_q   = 1'b0;
`endif

  // Lowest set bit wins; zero move gives zero-length N/E legs
  always_comb begin
    v_north = 1'b1;
    v_sq    = 3'd0;
    h_east  = 1'b1;
    h_sq    = 3'd0;
    casez (move)
      8'b???????1: begin v_north = 1'b1; v_sq = 3'd2; h_east = 1'b1; h_sq = 3'd1; end
      8'b??????10: begin v_north = 1'b1; v_sq = 3'd2; h_east = 1'b0; h_sq = 3'd1; end
      8'b?????100: begin v_north = 1'b1; v_sq = 3'd1; h_east = 1'b0; h_sq = 3'd2; end
      8'b????1000: begin v_north = 1'b0; v_sq = 3'd1; h_east = 1'b0; h_sq = 3'd2; end
      8'b???10000: begin v_north = 1'b0; v_sq = 3'd2; h_east = 1'b0; h_sq = 3'd1; end
      8'b??100000: begin v_north = 1'b0; v_sq = 3'd2; h_east = 1'b1; h_sq = 3'd1; end
      8'b?1000000: begin v_north = 1'b0; v_sq = 3'd1; h_east = 1'b1; h_sq = 3'd2; end
      8'b10000000: begin v_north = 1'b1; v_sq = 3'd1; h_east = 1'b1; h_sq = 3'd2; end
      default: ;
    endcase
  end

  assign cmd_v = {4'h4, (v_north ? 8'h00 : 8'h7F), 1'b0, v_sq};
  assign cmd_h = {4'h5, (h_east ? 8'hBF : 8'h3F), 1'b0, h_sq};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:      if (start_tour) nxt = VERT;
      VERT:      if (clr_cmd_rdy) nxt = VERT_WAIT;
      VERT_WAIT: if (send_resp) nxt = abort_q ? IDLE : HORZ;
      HORZ:      if (clr_cmd_rdy) nxt = HORZ_WAIT;
      HORZ_WAIT: if (send_resp) nxt = (last || abort_q) ? IDLE : VERT;
      default:   nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mv_indx <= 5'd0;
    else if (state != IDLE && nxt == IDLE)
      mv_indx <= 5'd0;
    else if (state == IDLE && start_tour)
      mv_indx <= 5'd0;
    else if (state == HORZ_WAIT && nxt == VERT)
      mv_indx <= mv_indx + 5'd1;
  end

  always_comb begin
    cmd              = cmd_v;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = abort_set;
    resp             = 8'h5A;
    unique case (state)
      IDLE: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = 8'hA5;
      end
      VERT:      cmd_rdy = 1'b1;
      VERT_WAIT: cmd = cmd_v;
      HORZ: begin
        cmd     = cmd_h;
        cmd_rdy = 1'b1;
      end
      HORZ_WAIT: begin
        cmd  = cmd_h;
        resp = last ? 8'hA5 : 8'h5A;
      end
      default: ;
    endcase
    if (state != IDLE && abort_q)
      resp = 8'hA5;
  end

endmodule

// File: doc/tour_cmd.md
# tour_cmd

Command issuer for the tour: sits between the UART wrapper, tour_logic and cmd_proc. In idle it passes UART commands straight through to cmd_proc. When cmd_proc raises tour_go, it walks the 24 solved knight moves from tour_logic. Each knight move becomes two 16-bit move commands: a vertical leg, then a horizontal leg with fanfare. Each command is handshaked with cmd_proc, and the response byte returned to the UART transmitter is selected here.

## Interface
Parameters:
- NUM_MOVES, 24: knight moves per tour; mv_indx runs 0..NUM_MOVES-1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start_tour  in  1  tour_go pulse from cmd_proc.
- move  in  8  one-hot knight move from tour_logic for current mv_indx.
- mv_indx  out  5  index of the move being issued.
- cmd_UART  in  16  command from UART wrapper.
- cmd_rdy_UART  in  1  UART command valid.
- clr_cmd_rdy_UART  out  1  clear to UART wrapper.
- cmd  out  16  command to cmd_proc.
- cmd_rdy  out  1  command valid to cmd_proc.
- clr_cmd_rdy  in  1  command accepted, from cmd_proc.
- send_resp  in  1  command complete, from cmd_proc.
- resp  out  8  response byte to UART transmitter.

## Operation
- States: IDLE, VERT, VERT_WAIT, HORZ, HORZ_WAIT.
- IDLE behaviour:
  - Passthrough: cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy.
  - start_tour → mv_indx<=0, go to VERT.
- Outside IDLE: clr_cmd_rdy_UART=0 and UART commands stay pending.
- VERT: cmd=vertical command, cmd_rdy=1. On clr_cmd_rdy → VERT_WAIT.
- VERT_WAIT: cmd held, cmd_rdy=0. On send_resp → HORZ.
- HORZ: cmd=horizontal command, cmd_rdy=1. On clr_cmd_rdy → HORZ_WAIT.
- HORZ_WAIT: cmd held, cmd_rdy=0. On send_resp:
  - mv_indx==NUM_MOVES-1 → IDLE, mv_indx<=0.
  - Otherwise mv_indx<=mv_indx+1 → VERT.
- Command format: {opcode[3:0], heading[7:0], 1'b0, squares[2:0]}.
  - Vertical opcode 4'h4. Horizontal opcode 4'h5 (fanfare).
  - Headings: N 8'h00, W 8'h3F, S 8'h7F, E 8'hBF.
- Move decode as (dx,dy):
  - Bit0 (+1,+2), bit1 (-1,+2), bit2 (-2,+1), bit3 (-2,-1).
  - Bit4 (-1,-2), bit5 (+1,-2), bit6 (+2,-1), bit7 (+2,+1).
  - Vertical leg: heading N if dy>0 else S, squares=|dy|.
  - Horizontal leg: heading E if dx>0 else W, squares=|dx|.
- Example: bit0 → 16'h4002 then 16'h5BF1. Bit3 → 16'h47F1 then 16'h53F2.
- Non-one-hot move: lowest set bit wins. move==8'h00 → 16'h4000 then 16'h5BF0.
- resp values:
  - 8'hA5 in IDLE.
  - 8'hA5 in HORZ_WAIT when mv_indx==NUM_MOVES-1.
  - Otherwise 8'h5A.
  - Combinational from state, valid whenever send_resp is high.

## Timing
- Reset: state IDLE, mv_indx=0, resp=8'hA5. cmd, cmd_rdy and clr_cmd_rdy_UART follow passthrough (0 while UART inputs are 0).
- start_tour at cycle t → cmd_rdy=1 with vertical command from cycle t+1.
- clr_cmd_rdy at cycle t → cmd_rdy=0 from t+1; cmd stays stable until the next send_resp.
- Ignored inputs:
  - send_resp in VERT or HORZ (before acceptance).
  - clr_cmd_rdy in a WAIT state.
  - start_tour outside IDLE.
- move is sampled combinationally. tour_logic holds it stable while mv_indx is constant.
- mv_indx updates on the send_resp edge. The next vertical command appears one cycle later.
- Reset asserted mid-tour → immediate IDLE, mv_indx=0, no response generated.

## Configuration
- TOUR_CMD_ABORT_EN defined:
  - Trigger: in any non-IDLE state, cmd_rdy_UART with cmd_UART[15:12]==4'hF sets an abort flag and pulses clr_cmd_rdy_UART for one cycle.
  - The command in flight completes normally.
  - At the next send_resp the block returns to IDLE with mv_indx=0 and resp=8'hA5. The abort flag clears.
- Not defined: no abort logic. UART commands are fully ignored during a tour and remain pending until IDLE.

## Test plan
- Reset, cmd_UART=16'h2000, cmd_rdy_UART=1 → cmd=16'h2000, cmd_rdy=1; clr_cmd_rdy pulse → clr_cmd_rdy_UART pulse the same cycle; resp=8'hA5.
- start_tour, move=8'h01, model cmd_proc handshake → cmd 16'h4002 then 16'h5BF1, resp 8'h5A, mv_indx 0→1.
- All eight one-hot moves → correct vertical/horizontal command pairs, e.g. 8'h40 → 16'h47F1 then 16'h5BF2.
- Full 24-move tour → 48 commands, 47 responses 8'h5A then one 8'hA5, returns to IDLE with mv_indx=0.
- Mid-tour: start_tour re-pulse and early send_resp → no state or index change; rst_n low → IDLE immediately.
- With TOUR_CMD_ABORT_EN: cmd_UART=16'hF000 during VERT_WAIT at mv_indx=5 → clr_cmd_rdy_UART pulse, then IDLE after send_resp, resp=8'hA5, mv_indx=0.
